ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, etc.) to the keyboard.
//  Drives the shared kclk/kdata lines open-drain and sits beside the PS/2 keycode receiver on the same pins.
//  Runs the inhibit, request-to-send, 11-bit frame and ACK check, then reports done or err.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles kclk is held low before request-to-send (100 us at 50 MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles between kclk falling edges, or waiting for release, before abort (20 ms)
//  FILTER_LEN      4        consecutive equal synced samples required to change a filtered line level
// PORTS
//  clk       in   1  50 MHz system clock
//  rst_n     in   1  asynchronous, active-low reset
//  tx_data   in   8  command byte to send
//  tx_valid  in   1  request; byte accepted when tx_valid && tx_ready
//  tx_ready  out  1  high in IDLE only
//  kclk_in   in   1  raw PS/2 clock pin level
//  kdata_in  in   1  raw PS/2 data pin level
//  kclk_oe   out  1  1 = pull kclk low, 0 = release (pad is open-drain, pulled up)
//  kdata_oe  out  1  1 = pull kdata low, 0 = release
//  busy      out  1  high from acceptance until return to IDLE
//  done      out  1  one-cycle pulse: frame ACKed by device
//  err       out  1  one-cycle pulse: NACK or timeout
// BEHAVIOUR
//  Reset: tx_ready=1; busy, done, err, kclk_oe, kdata_oe = 0; FSM=IDLE. Lines are released immediately (async).
//  Inputs: 2-flop synchronizer, then FILTER_LEN glitch filter. fall = filtered kclk 1->0, one-cycle strobe.
//  Accept: latch tx_data and compute odd parity (parity = ~^tx_data). tx_ready=0 and busy=1 from the next cycle.
//  FSM:
//   IDLE     -> INHIBIT on accept
//   INHIBIT  kclk_oe=1 for exactly INHIBIT_CYCLES clk cycles, then in the same cycle kdata_oe=1 and kclk_oe=0 -> FRAME
//   FRAME    on each fall, bit index n increments 0..9 and the line is updated within 1 cycle:
//            n=0..7 data bit n (LSB first); n=8 parity; n=9 stop.
//            kdata_oe = ~bit, so the stop bit releases the line.
//            The start bit (0) is already on the line from INHIBIT. After the stop bit -> ACK
//   ACK      on the next fall, sample filtered kdata. 0 -> WAIT_REL with ack_ok; 1 -> WAIT_REL with nack
//   WAIT_REL wait until filtered kclk=1 and kdata=1, then pulse done (ack_ok) or err (nack) -> IDLE
//  Timeout: counter clears on every fall and on entry to FRAME. In FRAME/ACK/WAIT_REL, reaching TIMEOUT_CYCLES
//   releases both lines, pulses err and returns to IDLE. INHIBIT is never subject to timeout.
//  Simultaneous events: a fall on the same cycle as timeout expiry is processed as a fall (counter clears).
//   tx_valid while busy is ignored. done and err never assert together.
//  Reset mid-frame: both oe outputs drop asynchronously; no done/err pulse; the next request restarts the full sequence.
//  Latency: tx_ready returns high the cycle after the done/err pulse.
//  Never drive kclk_oe outside INHIBIT. Never drive kdata_oe in IDLE, ACK or WAIT_REL.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//   On NACK or timeout of the first attempt, re-run from INHIBIT with the latched byte, once.
//   err pulses only if the retry also fails. busy stays high throughout.
//  PS2_TX_RETRY_EN undefined: the first failure pulses err immediately; no retry logic is synthesized.
// TESTING  (bench device model, kclk period 80 us; sim overrides INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000)
//  send 0xED, model ACKs -> kclk_oe high exactly 50 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; done=1 x1
//  send 0x01 -> parity bit sampled 0; send 0xFF -> parity bit 1; both complete with done
//  model NACKs (kdata=1 at ack fall), retry undefined -> err=1 x1, no done, tx_ready=1 the next cycle
//  model never toggles kclk after request -> err exactly 2000 cycles after FRAME entry; both oe=0
//  rst_n low after 4th data bit -> kdata_oe=0 and kclk_oe=0 the same cycle; the next 0xF4 send completes normally
//  PS2_TX_RETRY_EN defined, first NACK then ACK -> two full frames, one done, no err; busy stays high throughout

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK check, done/err report.
// Optional PS2_TX_RETRY_EN: a failed first attempt is re-run once from INHIBIT before err is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, FRAME, ACK, WAIT_REL} state_t;

    state_t             state, state_n;
    logic [1:0]         kclk_sync, kdata_sync;
    logic               kclk_filt, kdata_filt, kclk_prev;
    logic [FLT_W-1:0]   kclk_fcnt, kdata_fcnt;
    logic               fall;
    logic [9:0]         frame_q, frame_n;
    logic [3:0]         bit_idx, bit_idx_n;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_n;
    logic [TO_W-1:0]    to_cnt, to_cnt_n;
    logic               ack_ok, ack_ok_n;
    logic               kclk_oe_n, kdata_oe_n, done_n, err_n;
    logic               fail;
    logic               can_retry;

    // Lines idle high, so the synchronizers and filters reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kclk_sync  <= 2'b11;
            kdata_sync <= 2'b11;
            kclk_filt  <= 1'b1;
            kdata_filt <= 1'b1;
            kclk_prev  <= 1'b1;
            kclk_fcnt  <= '0;
            kdata_fcnt <= '0;
        end else begin
            kclk_sync  <= {kclk_sync[0], kclk_in};
            kdata_sync <= {kdata_sync[0], kdata_in};
            kclk_prev  <= kclk_filt;
            if (kclk_sync[1] == kclk_filt) begin
                kclk_fcnt <= '0;
            end else if (kclk_fcnt == FLT_LAST) begin
                kclk_filt <= kclk_sync[1];
                kclk_fcnt <= '0;
            end else begin
                kclk_fcnt <= kclk_fcnt + 1'b1;
            end
            if (kdata_sync[1] == kdata_filt) begin
                kdata_fcnt <= '0;
            end else if (kdata_fcnt == FLT_LAST) begin
                kdata_filt <= kdata_sync[1];
                kdata_fcnt <= '0;
            end else begin
                kdata_fcnt <= kdata_fcnt + 1'b1;
            end
        end
    end

    assign fall = kclk_prev & ~kclk_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame_q  <= '0;
            bit_idx  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            ack_ok   <= 1'b0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            frame_q  <= frame_n;
            bit_idx  <= bit_idx_n;
            inh_cnt  <= inh_cnt_n;
            to_cnt   <= to_cnt_n;
            ack_ok   <= ack_ok_n;
            kclk_oe  <= kclk_oe_n;
            kdata_oe <= kdata_oe_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // A done/err pulse holds the current state for one cycle so tx_ready rises after the pulse.
    always_comb begin
        state_n    = state;
        frame_n    = frame_q;
        bit_idx_n  = bit_idx;
        inh_cnt_n  = inh_cnt;
        to_cnt_n   = to_cnt;
        ack_ok_n   = ack_ok;
        kclk_oe_n  = kclk_oe;
        kdata_oe_n = kdata_oe;
        done_n     = 1'b0;
        err_n      = 1'b0;
        fail       = 1'b0;
        if (done || err) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame_n   = {1'b1, ~^tx_data, tx_data};
                        inh_cnt_n = '0;
                        kclk_oe_n = 1'b1;
                        state_n   = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        kclk_oe_n  = 1'b0;
                        kdata_oe_n = 1'b1;
                        bit_idx_n  = '0;
                        to_cnt_n   = '0;
                        state_n    = FRAME;
                    end else begin
                        inh_cnt_n = inh_cnt + 1'b1;
                    end
                end
                FRAME: begin
                    if (fall) begin
                        kdata_oe_n = ~frame_q[bit_idx];
                        bit_idx_n  = bit_idx + 1'b1;
                        to_cnt_n   = '0;
                        if (bit_idx == 4'd9) begin
                            state_n = ACK;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (fall) begin
                        ack_ok_n = ~kdata_filt;
                        to_cnt_n = '0;
                        state_n  = WAIT_REL;
                    end else if (to_cnt == TO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (kclk_filt && kdata_filt) begin
                        if (ack_ok) begin
                            done_n = 1'b1;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (fall) begin
                        to_cnt_n = '0;
                    end else if (to_cnt == TO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        if (fail) begin
            kdata_oe_n = 1'b0;
            if (can_retry) begin
                kclk_oe_n = 1'b1;
                inh_cnt_n = '0;
                state_n   = INHIBIT;
            end else begin
                kclk_oe_n = 1'b0;
                err_n     = 1'b1;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    logic retried;

    // One retry per accepted byte; cleared whenever the transmitter is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retried <= 1'b0;
        end else if (state == IDLE) begin
            retried <= 1'b0;
        end else if (fail) begin
            retried <= 1'b1;
        end
    end

    assign can_retry = ~retried;
`else
    assign can_retry = 1'b0;
`endif

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
